// File: rtl/beep_pkg.sv
// beep_driver shared definitions.
// State encoding and ms-to-cycles helpers.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int ms_to_cyc(
    input int clk_freq,
    input int ms
  );
    return clk_freq / 1000 * ms;
  endfunction

  // Bits needed to hold 0..n-1, never below 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beep_driver_tone_gen.sv
// Square-wave generator for the buzzer.
// Registered output, high phase first after restart.
module tone_gen
  import beep_pkg::*;
#(
  parameter int HALF = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic wave
);

  localparam int W = cnt_w(HALF);
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      wave <= 1'b1;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beep_driver.sv
// Turns trigger pulses into queued fixed-length beeps.
// FSM, beep/gap timer and saturating pending counter.
module beep_driver
  import beep_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TONE_HZ  = 2_000,
  parameter int BEEP_MS  = 50,
  parameter int GAP_MS   = 50,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_trig,
  input  logic              i_clear,
  output logic              o_buzz,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam int HALF     = CLK_FREQ / (2 * TONE_HZ);
  localparam int BEEP_CYC = ms_to_cyc(CLK_FREQ, BEEP_MS);
  localparam int GAP_CYC  = ms_to_cyc(CLK_FREQ, GAP_MS);
  localparam int CNT_MAX  =
    (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int CW       = cnt_w(CNT_MAX);

  localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PMAX  = '1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  logic con;
  logic acc;
  logic drop;
  logic beep_end;
  logic gap_end;
  logic tone_en;

  assign con  = (state == IDLE) && (pending != '0);
  assign acc  = i_trig && !i_clear &&
                ((pending != PMAX) || con);
  assign drop = i_trig && !i_clear &&
                (pending == PMAX) && !con;

  assign beep_end = (state == BEEP) && (cnt == BEEP_LAST);
  assign gap_end  = (state == GAP) && (cnt == GAP_LAST);

  // Tone runs on every cycle whose next state is BEEP.
  assign tone_en = !i_clear &&
                   (con || ((state == BEEP) && !beep_end));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (i_clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (con) begin
            state <= BEEP;
            cnt   <= '0;
          end
        end
        BEEP: begin
          if (beep_end) begin
            state <= GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (i_clear) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending + PEND_W'(acc) - PEND_W'(con);
      overflow <= drop;
    end
  end

  tone_gen #(
    .HALF(HALF)
  ) u_tone (
    .clk    (clk),
    .reset  (reset),
    .en     (tone_en),
    .restart(con),
    .wave   (o_buzz)
  );

  assign o_busy     = (state != IDLE);
  assign o_pending  = pending;
  assign o_overflow = overflow;

endmodule
